// File: rtl/button_event_queue.sv
// button_event_queue: turns the debouncer's one-cycle press pulses into a
// stream of 3-bit button codes. Presses are held in a pending register,
// serialised lowest index first into a small circular FIFO, and drained by
// a consumer through a valid/ready handshake.
// Optional feature macro: BTN_DROP_CNT_EN enables the saturating counter of
// coalesced (dropped) presses; without it drop_count is tied to zero.
module button_event_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [4:0]               btn_pulse,
  output logic                     evt_valid,
  output logic [CW-1:0]            evt_code,
  input  logic                     evt_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [4:0]               pending,
  output logic [7:0]               drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam logic [NW-1:0] FULL_CNT = NW'(DEPTH);

  logic [4:0]    pend_r;
  logic [CW-1:0] mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [NW-1:0] count_r;
  logic          evt_valid_r;
  logic [CW-1:0] evt_code_r;

  logic [4:0]    sel_onehot_s;
  logic [CW-1:0] sel_code_s;
  logic          pop_s;
  logic          push_s;
  logic [4:0]    clr_s;
  logic [4:0]    pend_next_s;
  logic [AW-1:0] rd_next_s;
  logic [AW-1:0] wr_next_s;
  logic [NW-1:0] count_next_s;
  logic [CW-1:0] head_next_s;
  logic [CW-1:0] code_next_s;

  // Lowest-index pending button wins the serialiser slot this cycle.
  always_comb begin
    sel_onehot_s = pend_r & (~pend_r + 5'd1);
    sel_code_s   = CW'(0);
    casez (pend_r)
      5'b????1: sel_code_s = CW'(0);
      5'b???10: sel_code_s = CW'(1);
      5'b??100: sel_code_s = CW'(2);
      5'b?1000: sel_code_s = CW'(3);
      5'b10000: sel_code_s = CW'(4);
      default:  sel_code_s = CW'(0);
    endcase
  end

  // Handshake, push permission and next-state of pending bits, pointers
  // and count. A full FIFO still accepts a push when the head leaves on
  // the same edge.
  always_comb begin
    pop_s       = evt_valid_r & evt_ready;
    push_s      = (pend_r != 5'd0) & ((count_r != FULL_CNT) | pop_s);
    clr_s       = push_s ? sel_onehot_s : 5'd0;
    pend_next_s = (pend_r & ~clr_s) | btn_pulse;
    rd_next_s   = pop_s  ? rd_ptr_r + AW'(1) : rd_ptr_r;
    wr_next_s   = push_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + NW'(1);
      2'b01:   count_next_s = count_r - NW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Next head of the FIFO: the word being written this edge when it lands
  // in the head slot, otherwise storage at the next read pointer.
  always_comb begin
    if (push_s && (rd_next_s == wr_ptr_r)) begin
      head_next_s = sel_code_s;
    end else begin
      head_next_s = mem_r[rd_next_s];
    end
    code_next_s = (count_next_s != NW'(0)) ? head_next_s : CW'(0);
  end

  // FIFO data storage; contents are only meaningful under count_r.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= sel_code_s;
    end
  end

  // Control state and registered consumer outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_r      <= 5'd0;
      rd_ptr_r    <= AW'(0);
      wr_ptr_r    <= AW'(0);
      count_r     <= NW'(0);
      evt_valid_r <= 1'b0;
      evt_code_r  <= CW'(0);
    end else begin
      pend_r      <= pend_next_s;
      rd_ptr_r    <= rd_next_s;
      wr_ptr_r    <= wr_next_s;
      count_r     <= count_next_s;
      evt_valid_r <= (count_next_s != NW'(0));
      evt_code_r  <= code_next_s;
    end
  end

  assign evt_valid  = evt_valid_r;
  assign evt_code   = evt_code_r;
  assign fifo_count = count_r;
  assign pending    = pend_r;

`ifdef BTN_DROP_CNT_EN
  logic [7:0] drop_r;
  logic [4:0] coalesced_s;
  logic [8:0] drop_sum_s;

  function automatic logic [2:0] popcount5(input logic [4:0] v);
    popcount5 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]) + 3'(v[4]);
  endfunction

  // A press merges into an already pending, not-being-cleared bit.
  always_comb begin
    coalesced_s = btn_pulse & pend_r & ~clr_s;
    drop_sum_s  = {1'b0, drop_r} + 9'(popcount5(coalesced_s));
  end

  // Saturating count of coalesced presses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_r <= 8'd0;
    end else if (drop_sum_s > 9'd255) begin
      drop_r <= 8'd255;
    end else begin
      drop_r <= drop_sum_s[7:0];
    end
  end

  assign drop_count = drop_r;
`else
  assign drop_count = 8'd0;
`endif

endmodule

// File: doc/button_event_queue.md
# button_event_queue

Sits directly downstream of the button debouncer. It accepts the debouncer's 5-bit vector of one-cycle press pulses and serialises every set bit into a 3-bit event code. Codes go into a small FIFO, and a consumer (menu FSM, display controller) drains them through a valid/ready handshake. No press is lost while the consumer stalls unless the same button is pressed again before its earlier press has been queued.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- CW, 3: event code width; must satisfy 2^CW >= 5.
- clk  in  1: system clock, 100 MHz.
- reset  in  1: asynchronous, active-high; clears all state.
- btn_pulse  in  5: one-cycle press pulses from debouncer; any combination of bits may be set in one cycle.
- evt_valid  out  1: head of FIFO holds an event.
- evt_code  out  CW: button index 0..4 of head event; 0 when evt_valid=0.
- evt_ready  in  1: consumer accepts head when evt_valid && evt_ready at a rising edge.
- fifo_count  out  $clog2(DEPTH)+1: entries currently held.
- pending  out  5: pulses captured but not yet queued.
- drop_count  out  8: coalesced-press counter (see Configuration).

## Operation
- Pending register P[4:0]. Every edge: P <= (P & ~clr) | btn_pulse, where clr is the one-hot bit pushed this cycle.
- Serialiser: each cycle selects the lowest-index set bit of P (index 0 highest priority) and pushes its index as a code when a push is allowed.
- Push allowed when fifo_count < DEPTH, or when fifo_count == DEPTH and a pop occurs in the same cycle.
- FIFO: circular buffer with rd/wr pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register. Push and pop in the same cycle leave the count unchanged.
- Coalescing: btn_pulse[i] arriving while P[i] is already set and not being cleared that cycle merges into one event, and the press counts as dropped.
- A pulse on bit i in the same cycle that P[i] is pushed is a new event: P[i] stays 1. This is not a drop.
- Backpressure never drops an entry already in the FIFO. The only loss mechanism is coalescing in P.
- Reset, including mid-operation: P=0, pointers=0, fifo_count=0, evt_valid=0, evt_code=0, pending=0, drop_count=0. In-flight events are discarded.

## Timing
- Pulse sampled at edge E sets P after E. The push occurs at edge E+1 if allowed, and evt_valid goes high after E+1 when the FIFO was empty.
- Minimum latency from pulse to evt_valid: 2 cycles.
- Throughput: one push and one pop per cycle. A 5-bit simultaneous pulse drains in 5 consecutive cycles with evt_ready=1.
- evt_valid and evt_code are registered and come from FIFO head storage. No combinational path from btn_pulse or evt_ready to any output.
- evt_code is stable while evt_valid=1 && evt_ready=0.
- evt_valid stays high with no gap across back-to-back pops while fifo_count >= 2 or a push lands in the same cycle.

## Configuration
- BTN_DROP_CNT_EN defined:
  - drop_count increments by 1 per coalesced press and saturates at 255.
  - When several bits coalesce in one cycle, it adds their popcount, still saturating.
- BTN_DROP_CNT_EN undefined:
  - The counter logic is absent and drop_count is tied to 8'd0.
  - All other behaviour is identical.

## Test plan
- Single press: btn_pulse=5'b00100 for 1 cycle, evt_ready=1 -> evt_valid=1 with evt_code=2 two cycles later for exactly 1 cycle; fifo_count returns to 0.
- Multi-bit press: btn_pulse=5'b10101 for 1 cycle, evt_ready=1 -> codes 0, 2, 4 on consecutive cycles.
- Backpressure and drop:
  - Stimulus: DEPTH=4, evt_ready=0, pulses on bits 0,1,2,3,4 on separate cycles.
  - Expected: fifo_count=4, pending=5'b10000.
  - Pulse bit 4 again -> drop_count=1 when BTN_DROP_CNT_EN is defined, 0 when undefined.
  - Raise evt_ready -> codes 0,1,2,3,4 in order.
- Full push+pop: FIFO full, P[1]=1, evt_ready=1 -> pop and push occur on the same edge; fifo_count stays 4; code 1 appears last.
- Push/pulse collision: P[3]=1 being pushed while btn_pulse[3]=1 -> two code-3 events delivered, drop_count unchanged.
- Reset mid-operation: assert reset asynchronously with 3 entries queued and P=5'b00011 -> evt_valid, fifo_count, pending and drop_count all 0 immediately. After release, no stale events appear.
